// File: rtl/pipe_hazard_ctrl_if.sv
// Bus between the pipeline datapath and the hazard controller.
// master = datapath side (drives status, receives controls); slave = controller.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             idex_memread;
  logic [4:0]       idex_rd;
  logic [4:0]       ifid_rs1;
  logic [4:0]       ifid_rs2;
  logic             branch_taken;
  logic             exmem_memread;
  logic             exmem_memwrite;
  logic             dmem_ready;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             dmem_req;
  logic             mem_busy;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output idex_memread, idex_rd, ifid_rs1, ifid_rs2, branch_taken,
           exmem_memread, exmem_memwrite, dmem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           dmem_req, mem_busy, mem_err, stall_cycles, flush_count
  );

  modport slave (
    input  idex_memread, idex_rd, ifid_rs1, ifid_rs2, branch_taken,
           exmem_memread, exmem_memwrite, dmem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           dmem_req, mem_busy, mem_err, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: data-memory wait FSM with timeout, branch flush, load-use stall.
// Define PIPE_HAZARD_CTRL_PERF_EN to build the stall/flush performance counters (else tied 0).
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 16,  // legal range 2..255
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  // Last wait count that may still see dmem_ready; one more miss means timeout.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 2);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       mem_err_q;

  logic mem_access;
  logic load_use;

  assign mem_access = bus.exmem_memread | bus.exmem_memwrite;
  assign load_use   = bus.idex_memread && (bus.idex_rd != 5'd0) &&
                      ((bus.idex_rd == bus.ifid_rs1) || (bus.idex_rd == bus.ifid_rs2));

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem_access && !bus.dmem_ready) begin
            state    <= ST_WAIT;
            wait_cnt <= '0;
          end
        end
        ST_WAIT: begin
          if (bus.dmem_ready) begin
            state <= ST_IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            state     <= ST_ERR;
            mem_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_ERR: begin
          mem_err_q <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  logic mem_stall;
  logic dmem_req_c;
  logic mem_busy_c;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    mem_stall  = 1'b0;
    dmem_req_c = 1'b0;
    mem_busy_c = 1'b0;
    case (state)
      ST_IDLE: begin
        dmem_req_c = mem_access;
        mem_stall  = mem_access & ~bus.dmem_ready;
      end
      ST_WAIT: begin
        dmem_req_c = 1'b1;
        mem_busy_c = 1'b1;
        mem_stall  = ~bus.dmem_ready;
      end
      default: begin
        mem_stall = 1'b1;
      end
    endcase
  end

  logic pc_en_c;
  logic ifid_en_c;
  logic idex_en_c;
  logic exmem_en_c;
  logic memwb_en_c;
  logic ifid_flush_c;
  logic idex_flush_c;

  // Memory stall freezes everything; branch and load-use only act once the pipe moves,
  // which includes the cycle the pending access completes.
  always_comb begin
    pc_en_c      = 1'b1;
    ifid_en_c    = 1'b1;
    idex_en_c    = 1'b1;
    exmem_en_c   = 1'b1;
    memwb_en_c   = 1'b1;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;
    if (mem_stall) begin
      pc_en_c    = 1'b0;
      ifid_en_c  = 1'b0;
      idex_en_c  = 1'b0;
      exmem_en_c = 1'b0;
      memwb_en_c = 1'b0;
    end else if (bus.branch_taken) begin
      ifid_flush_c = 1'b1;
      idex_flush_c = 1'b1;
    end else if (load_use) begin
      pc_en_c      = 1'b0;
      ifid_en_c    = 1'b0;
      idex_flush_c = 1'b1;
    end
  end

  // Reset forces every control low immediately, aborting any access in flight.
  logic [4:0] en_g;
  logic [1:0] flush_g;

  assign en_g    = {5{rst_n}} & {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c};
  assign flush_g = {2{rst_n}} & {ifid_flush_c, idex_flush_c};

  assign bus.pc_en      = en_g[4];
  assign bus.ifid_en    = en_g[3];
  assign bus.idex_en    = en_g[2];
  assign bus.exmem_en   = en_g[1];
  assign bus.memwb_en   = en_g[0];
  assign bus.ifid_flush = flush_g[1];
  assign bus.idex_flush = flush_g[0];
  assign bus.dmem_req   = rst_n & dmem_req_c;
  assign bus.mem_busy   = rst_n & mem_busy_c;
  assign bus.mem_err    = mem_err_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  logic             any_stall;
  logic             any_flush;

  assign any_stall = ~(&en_g);
  assign any_flush = |flush_g;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (any_stall) stall_q <= stall_q + CNT_W'(1);
      if (any_flush) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign bus.stall_cycles = stall_q;
  assign bus.flush_count  = flush_q;
`else
  assign bus.stall_cycles = {CNT_W{1'b0}};
  assign bus.flush_count  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random traffic,
// all compared against a cycle-level behavioural model of the controller.
module tb_pipe_hazard_ctrl;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pc, ifid, idex, exmem, memwb, fl_ifid, fl_idex, req, busy, err;
  } out_t;

  int errors = 0;
  int checks = 0;

  // Model: "waiting for memory", "how many wait cycles missed", "locked in error".
  bit               m_wait;
  bit               m_err;
  int               m_waited;
  logic [CNT_W-1:0] m_stall;
  logic [CNT_W-1:0] m_flush;

  function automatic out_t model_out();
    out_t o;
    bit   access, frozen, hazard;
    o = '0;
    if (!rst_n) return o;
    if (m_err) begin
      o.err = 1'b1;
      return o;
    end
    access = bus.exmem_memread | bus.exmem_memwrite;
    o.req  = m_wait | access;
    o.busy = m_wait;
    frozen = (m_wait | access) & !bus.dmem_ready;
    if (frozen) return o;
    {o.pc, o.ifid, o.idex, o.exmem, o.memwb} = 5'b11111;
    hazard = bus.idex_memread && bus.idex_rd != 0 &&
             (bus.idex_rd == bus.ifid_rs1 || bus.idex_rd == bus.ifid_rs2);
    if (bus.branch_taken) begin
      o.fl_ifid = 1'b1;
      o.fl_idex = 1'b1;
    end else if (hazard) begin
      o.pc      = 1'b0;
      o.ifid    = 1'b0;
      o.fl_idex = 1'b1;
    end
    return o;
  endfunction

  function automatic out_t dut_out();
    return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
            bus.ifid_flush, bus.idex_flush, bus.dmem_req, bus.mem_busy, bus.mem_err};
  endfunction

  task automatic model_reset();
    m_wait   = 0;
    m_err    = 0;
    m_waited = 0;
    m_stall  = '0;
    m_flush  = '0;
  endtask

  task automatic drive(input bit mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input bit br, input bit ld, input bit st,
                       input bit rdy);
    @(negedge clk);
    bus.idex_memread   = mr;
    bus.idex_rd        = rd;
    bus.ifid_rs1       = rs1;
    bus.ifid_rs2       = rs2;
    bus.branch_taken   = br;
    bus.exmem_memread  = ld;
    bus.exmem_memwrite = st;
    bus.dmem_ready     = rdy;
    #3;
  endtask

  // Clock edge: move the model forward using this cycle's inputs and expected outputs.
  task automatic advance();
    out_t e;
    e = model_out();
    @(posedge clk);
    if (!rst_n) return;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    if (!(e.pc & e.ifid & e.idex & e.exmem & e.memwb)) m_stall = m_stall + 1;
    if (e.fl_ifid | e.fl_idex) m_flush = m_flush + 1;
`endif
    if (m_err) return;
    if (m_wait) begin
      if (bus.dmem_ready) m_wait = 0;
      else begin
        m_waited++;
        if (m_waited == TIMEOUT - 1) begin
          m_err  = 1;
          m_wait = 0;
        end
      end
    end else if ((bus.exmem_memread | bus.exmem_memwrite) && !bus.dmem_ready) begin
      m_wait   = 1;
      m_waited = 0;
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    bus.idex_memread   = 0;
    bus.branch_taken   = 0;
    bus.exmem_memread  = 0;
    bus.exmem_memwrite = 0;
    bus.dmem_ready     = 0;
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    bus.idex_memread = 1; bus.idex_rd = 5'd5; bus.ifid_rs1 = 5'd5; bus.ifid_rs2 = 5'd0;
    bus.branch_taken = 1; bus.exmem_memread = 1; bus.exmem_memwrite = 0; bus.dmem_ready = 0;
    #12;
    if (dut_out() !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=%b", dut_out(), 10'b0);
    end
    checks++;
    if (bus.stall_cycles !== '0 || bus.flush_count !== '0) begin
      errors++;
      $display("FAIL reset_counters got=%0d/%0d want=0/0", bus.stall_cycles, bus.flush_count);
    end
    checks++;
    pulse_reset();
    // First cycle out of reset: plain IDLE behaviour with a zero-wait access.
    drive(0, 0, 0, 0, 0, 1, 0, 1);
    if (dut_out() !== model_out() || bus.pc_en !== 1'b1 || bus.dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_idle got=%b want=%b", dut_out(), model_out());
    end
    checks++;
    advance();
  endtask

  task automatic test_load_use();
    // Load x5 in EX, ID reads x5 as rs1: one bubble.
    drive(1, 5, 5, 3, 0, 0, 0, 0);
    if (dut_out() !== model_out() || bus.pc_en !== 1'b0 || bus.ifid_en !== 1'b0 ||
        bus.idex_flush !== 1'b1 || bus.idex_en !== 1'b1) begin
      errors++;
      $display("FAIL load_use_rs1 got=%b want=%b", dut_out(), model_out());
    end
    checks++;
    advance();
    drive(0, 0, 5, 3, 0, 0, 0, 0);
    if (dut_out() !== model_out() || dut_out() !== 10'b11111_00_000) begin
      errors++;
      $display("FAIL load_use_resume got=%b want=%b", dut_out(), 10'b11111_00_000);
    end
    checks++;
    advance();
    drive(1, 9, 2, 9, 0, 0, 0, 0);
    if (dut_out() !== model_out()) begin
      errors++;
      $display("FAIL load_use_rs2 got=%b want=%b", dut_out(), model_out());
    end
    checks++;
    advance();
    // Load to x0 never stalls.
    drive(1, 0, 4, 0, 0, 0, 0, 0);
    if (dut_out() !== model_out() || bus.pc_en !== 1'b1 || bus.idex_flush !== 1'b0) begin
      errors++;
      $display("FAIL load_x0 got=%b want=%b", dut_out(), model_out());
    end
    checks++;
    advance();
  endtask

  task automatic test_mem_wait();
    logic [CNT_W-1:0] base;
    base = m_stall;
    for (int c = 1; c <= 4; c++) begin
      drive(0, 0, 0, 0, 0, 1, 0, c == 4);
      if (dut_out() !== model_out() || bus.mem_busy !== (c >= 2) || bus.pc_en !== (c == 4) ||
          bus.memwb_en !== (c == 4) || bus.dmem_req !== 1'b1) begin
        errors++;
        $display("FAIL mem_wait c%0d got=%b want=%b", c, dut_out(), model_out());
      end
      checks++;
      advance();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    if (bus.stall_cycles !== base + 3 || bus.stall_cycles !== m_stall) begin
      errors++;
      $display("FAIL mem_wait_stall_cnt got=%0d want=%0d", bus.stall_cycles, base + 3);
    end
`else
    if (bus.stall_cycles !== '0 || bus.mem_busy !== 1'b0) begin
      errors++;
      $display("FAIL mem_wait_stall_cnt got=%0d want=0", bus.stall_cycles);
    end
`endif
    checks++;
    advance();
  endtask

  task automatic test_branch_priority();
    logic [CNT_W-1:0] base;
    base = m_flush;
    drive(1, 7, 7, 1, 1, 0, 0, 0);
    if (dut_out() !== model_out() || bus.ifid_flush !== 1'b1 || bus.idex_flush !== 1'b1 ||
        bus.pc_en !== 1'b1 || bus.ifid_en !== 1'b1) begin
      errors++;
      $display("FAIL branch_over_load_use got=%b want=%b", dut_out(), model_out());
    end
    checks++;
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    if (bus.flush_count !== base + 1) begin
      errors++;
      $display("FAIL branch_flush_cnt got=%0d want=%0d", bus.flush_count, base + 1);
    end
`else
    if (bus.flush_count !== '0) begin
      errors++;
      $display("FAIL branch_flush_cnt got=%0d want=0", bus.flush_count);
    end
`endif
    checks++;
    advance();
    // Branch while memory stalls: no flush until the access completes.
    drive(1, 7, 7, 1, 1, 0, 1, 0);
    if (dut_out() !== model_out() || bus.ifid_flush !== 1'b0 || bus.idex_flush !== 1'b0) begin
      errors++;
      $display("FAIL branch_during_stall got=%b want=%b", dut_out(), model_out());
    end
    checks++;
    advance();
    drive(1, 7, 7, 1, 1, 0, 1, 1);
    if (dut_out() !== model_out() || bus.ifid_flush !== 1'b1 || bus.mem_busy !== 1'b1) begin
      errors++;
      $display("FAIL branch_on_resume got=%b want=%b", dut_out(), model_out());
    end
    checks++;
    advance();
  endtask

  task automatic test_timeout();
    for (int c = 1; c <= 8; c++) begin
      if (c <= 4) drive(0, 0, 0, 0, 0, 1, 0, 0);
      else        drive(0, 0, 0, 0, 0, 0, 0, 1);
      if (dut_out() !== model_out() || bus.mem_err !== (c >= 5) ||
          bus.mem_busy !== (c >= 2 && c <= 4) || bus.pc_en !== 1'b0) begin
        errors++;
        $display("FAIL timeout c%0d got=%b want=%b", c, dut_out(), model_out());
      end
      checks++;
      advance();
    end
    pulse_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    if (dut_out() !== model_out() || bus.mem_err !== 1'b0 || bus.pc_en !== 1'b1) begin
      errors++;
      $display("FAIL timeout_cleared got=%b want=%b", dut_out(), model_out());
    end
    checks++;
    advance();
  endtask

  task automatic test_reset_mid_wait();
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    advance();
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    if (bus.mem_busy !== 1'b1 || bus.dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_wait_busy got=%b want busy=1 req=1", dut_out());
    end
    checks++;
    #1 rst_n = 1'b0;
    #1;
    if (bus.dmem_req !== 1'b0 || dut_out() !== 10'b0) begin
      errors++;
      $display("FAIL mid_wait_reset_async got=%b want=%b", dut_out(), 10'b0);
    end
    checks++;
    pulse_reset();
    drive(0, 0, 0, 0, 0, 1, 0, 1);
    if (dut_out() !== model_out() || bus.mem_busy !== 1'b0 ||
        bus.stall_cycles !== '0 || bus.flush_count !== '0) begin
      errors++;
      $display("FAIL mid_wait_after_release got=%b want=%b cnt=%0d/%0d", dut_out(),
               model_out(), bus.stall_cycles, bus.flush_count);
    end
    checks++;
    advance();
  endtask

  task automatic test_random();
    int err_cycles = 0;
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 15,
            $urandom_range(0, 9) < 7);
      if (dut_out() !== model_out()) begin
        errors++;
        $display("FAIL random n%0d got=%b want=%b", n, dut_out(), model_out());
      end
      checks++;
      if (bus.stall_cycles !== m_stall || bus.flush_count !== m_flush) begin
        errors++;
        $display("FAIL random_cnt n%0d got=%0d/%0d want=%0d/%0d", n, bus.stall_cycles,
                 bus.flush_count, m_stall, m_flush);
      end
      checks++;
      advance();
      if (m_err) err_cycles++;
      if (err_cycles >= 3) begin
        err_cycles = 0;
        @(negedge clk);
        pulse_reset();
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mem_wait();
    test_branch_priority();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
